// File: rtl/rf_arb_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// The optional fairness state machine is enabled with RFWB_FAIRNESS_EN.
package rf_arb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the pipeline/MDU (master) and the write arbiter (slave).
// Optional fairness (RFWB_FAIRNESS_EN) only changes STALL behaviour, not the bundle.
interface regfile_write_arbiter_if;
  import rf_arb_pkg::*;

  logic                  WB_VALID;
  logic [REG_ADDR_W-1:0] WB_ADDR;
  logic [XLEN-1:0]       WB_DATA;
  // MDU handshake: a result transfers in every cycle where MDU_VALID and MDU_READY
  // are both high; the master holds VALID/ADDR/DATA stable until that cycle.
  logic                  MDU_VALID;
  logic [REG_ADDR_W-1:0] MDU_ADDR;
  logic [XLEN-1:0]       MDU_DATA;
  logic                  MDU_READY;
  logic                  MDU_ISSUE;
  logic [REG_ADDR_W-1:0] MDU_ISSUE_ADDR;
  logic [REG_ADDR_W-1:0] RS1;
  logic [REG_ADDR_W-1:0] RS2;
  logic                  RS1_BUSY;
  logic                  RS2_BUSY;
  logic                  STALL;
  logic                  WRITEENABLE;
  logic [REG_ADDR_W-1:0] WRITEADDRESS;
  logic [XLEN-1:0]       WRITEDATA;

  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, MDU_VALID, MDU_ADDR, MDU_DATA,
           MDU_ISSUE, MDU_ISSUE_ADDR, RS1, RS2,
    input  MDU_READY, RS1_BUSY, RS2_BUSY, STALL, WRITEENABLE, WRITEADDRESS, WRITEDATA
  );

  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, MDU_VALID, MDU_ADDR, MDU_DATA,
           MDU_ISSUE, MDU_ISSUE_ADDR, RS1, RS2,
    output MDU_READY, RS1_BUSY, RS2_BUSY, STALL, WRITEENABLE, WRITEADDRESS, WRITEDATA
  );
endinterface

// File: rtl/rf_arb_fifo.sv
// Circular FIFO holding MDU results until the write port is free.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// queued MDU results; tracks pending MDU destinations. Fairness: RFWB_FAIRNESS_EN.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  regfile_write_arbiter_if.slave  bus,
  output arb_state_e              dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam bit CFG_OK = (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0)
                          && (STARVE_LIMIT >= 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("regfile_write_arbiter: FIFO_DEPTH must be a power of two >= 2, STARVE_LIMIT >= 1");
  end

  wr_req_t               mdu_req, fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  wb_req, mdu_push, head_valid;
  logic                  grant_wb, grant_mdu, force_active;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [NUM_REGS-1:0]   busy_q, busy_n;

  // Address 0 is never a real write, so such requests are simply dropped.
  assign wb_req     = bus.WB_VALID && (bus.WB_ADDR != '0);
  assign mdu_push   = bus.MDU_VALID && !fifo_full && (bus.MDU_ADDR != '0);
  assign mdu_req    = '{addr: bus.MDU_ADDR, data: bus.MDU_DATA};
  assign head_valid = !fifo_empty;

  assign grant_mdu  = head_valid && (!wb_req || force_active);
  assign grant_wb   = wb_req && !force_active;

  assign bus.MDU_READY = (fifo_count < CW'(FIFO_DEPTH));

  rf_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_req_t))
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (mdu_push),
    .push_data (mdu_req),
    .pop       (grant_mdu),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A re-issue to the same register must win over the clear from its older result.
  always_comb begin
    busy_n = busy_q;
    if (grant_mdu) busy_n[fifo_head.addr] = 1'b0;
    if (bus.MDU_ISSUE && (bus.MDU_ISSUE_ADDR != '0)) busy_n[bus.MDU_ISSUE_ADDR] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q   <= grant_wb || grant_mdu;
      busy_q <= busy_n;
      if (grant_mdu) begin
        waddr_q <= fifo_head.addr;
        wdata_q <= fifo_head.data;
      end else if (grant_wb) begin
        waddr_q <= bus.WB_ADDR;
        wdata_q <= bus.WB_DATA;
      end else begin
        waddr_q <= '0;
        wdata_q <= '0;
      end
    end
  end

  assign bus.WRITEENABLE  = we_q;
  assign bus.WRITEADDRESS = waddr_q;
  assign bus.WRITEDATA    = wdata_q;
  assign bus.RS1_BUSY     = busy_q[bus.RS1];
  assign bus.RS2_BUSY     = busy_q[bus.RS2];

`ifdef RFWB_FAIRNESS_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] LIMIT = SCW'(STARVE_LIMIT);

  arb_state_e     state_q, state_n;
  logic [SCW-1:0] starve_q, starve_n;
  logic           stall_q;

  assign force_active = (state_q == FORCE);

  // starve counts consecutive cycles the head has been passed over.
  always_comb begin
    state_n  = state_q;
    starve_n = starve_q;
    case (state_q)
      IDLE: begin
        if (head_valid && !grant_mdu) begin
          starve_n = SCW'(1);
          state_n  = (starve_n >= LIMIT) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (grant_mdu) begin
          state_n  = IDLE;
          starve_n = '0;
        end else begin
          starve_n = starve_q + SCW'(1);
          if (starve_n >= LIMIT) state_n = FORCE;
        end
      end
      FORCE: begin
        state_n  = IDLE;
        starve_n = '0;
      end
      default: begin
        state_n  = IDLE;
        starve_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      starve_q <= starve_n;
      stall_q  <= (state_n == FORCE);
    end
  end

  assign bus.STALL = stall_q;
  assign dbg_state = state_q;
`else
  assign force_active = 1'b0;
  assign bus.STALL    = 1'b0;
  assign dbg_state    = IDLE;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes queued at stimulus time,
// checked in order by an independent write-port monitor. Honours RFWB_FAIRNESS_EN.
module tb_regfile_write_arbiter;
  import rf_arb_pkg::*;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  arb_state_e dbg_state;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  logic [36:0] exp_q[$];

  // ---------------- checking helpers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_addr(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [36:0] e;
    if (RESET && bus.WRITEENABLE) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got x%0d=0x%0h, want no write",
                 bus.WRITEADDRESS, bus.WRITEDATA);
      end else begin
        e = exp_q.pop_front();
        if ({bus.WRITEADDRESS, bus.WRITEDATA} !== e) begin
          miscompares++;
          $display("FAIL write_port: got x%0d=0x%0h, want x%0d=0x%0h",
                   bus.WRITEADDRESS, bus.WRITEDATA, e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.WB_VALID       = 1'b0;
    bus.WB_ADDR        = '0;
    bus.WB_DATA        = '0;
    bus.MDU_VALID      = 1'b0;
    bus.MDU_ADDR       = '0;
    bus.MDU_DATA       = '0;
    bus.MDU_ISSUE      = 1'b0;
    bus.MDU_ISSUE_ADDR = '0;
    bus.RS1            = '0;
    bus.RS2            = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.WB_VALID = v;
    bus.WB_ADDR  = a;
    bus.WB_DATA  = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.MDU_VALID = v;
    bus.MDU_ADDR  = a;
    bus.MDU_DATA  = d;
  endtask

  task automatic drive_issue(input logic v, input logic [4:0] a);
    bus.MDU_ISSUE      = v;
    bus.MDU_ISSUE_ADDR = a;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [0:6] ready_tbl;
    int k;
    ready_tbl = 7'b1100011;
    idle_inputs();

    // reset state
    repeat (2) @(posedge CLK);
    sample();
    check_bit ("rst_we",    bus.WRITEENABLE, 1'b0);
    check_addr("rst_addr",  bus.WRITEADDRESS, 5'd0);
    check_word("rst_data",  bus.WRITEDATA, 32'h0);
    check_bit ("rst_stall", bus.STALL, 1'b0);
    check_bit ("rst_ready", bus.MDU_READY, 1'b1);
    check_bit ("rst_rs1",   bus.RS1_BUSY, 1'b0);
    step();
    RESET = 1'b1;

    // WB and FIFO head in the same cycle: WB first, head next
    step(); drive_mdu(1'b1, 5'd7, 32'h22);
    sample(); check_bit("r030_ready", bus.MDU_READY, 1'b1);
    step(); drive_mdu(1'b0, 5'd0, 32'h0); drive_wb(1'b1, 5'd5, 32'h11);
    expect_write(5'd5, 32'h11); expect_write(5'd7, 32'h22);
    step(); drive_wb(1'b0, 5'd0, 32'h0);
    sample(); check_addr("r030_n1_addr", bus.WRITEADDRESS, 5'd5);
    step();
    sample(); check_addr("r030_n2_addr", bus.WRITEADDRESS, 5'd7);
    repeat (2) step();

    // FIFO fills under continuous WB, third result held, order kept
    for (int i = 0; i < 4; i++) expect_write(5'(10 + i), 32'h100 + 32'(i));
    expect_write(5'd20, 32'hA1); expect_write(5'd21, 32'hA2); expect_write(5'd22, 32'hA3);
    for (int c = 0; c < 7; c++) begin
      step();
      drive_wb(c < 4, 5'(10 + c), 32'h100 + 32'(c));
      if (c == 0)      drive_mdu(1'b1, 5'd20, 32'hA1);
      else if (c == 1) drive_mdu(1'b1, 5'd21, 32'hA2);
      else if (c <= 5) drive_mdu(1'b1, 5'd22, 32'hA3);
      else             drive_mdu(1'b0, 5'd0, 32'h0);
      sample();
      check_bit($sformatf("r031_ready_c%0d", c), bus.MDU_READY, ready_tbl[c]);
    end
    step(); idle_inputs();
    repeat (3) step();

    // scoreboard set/clear
    drive_issue(1'b1, 5'd9); bus.RS1 = 5'd9; bus.RS2 = 5'd0;
    sample(); check_bit("r032_busy_pre", bus.RS1_BUSY, 1'b0);
    step(); drive_issue(1'b0, 5'd0); drive_mdu(1'b1, 5'd9, 32'h99); expect_write(5'd9, 32'h99);
    sample(); check_bit("r032_busy_set", bus.RS1_BUSY, 1'b1);
    check_bit("r032_rs2_zero", bus.RS2_BUSY, 1'b0);
    step(); drive_mdu(1'b0, 5'd0, 32'h0);
    sample(); check_bit("r032_busy_grant", bus.RS1_BUSY, 1'b1);
    step();
    sample(); check_bit("r032_busy_clear", bus.RS1_BUSY, 1'b0);
    step(); drive_issue(1'b1, 5'd9);
    step(); drive_issue(1'b0, 5'd0); drive_mdu(1'b1, 5'd9, 32'h9A); expect_write(5'd9, 32'h9A);
    step(); drive_mdu(1'b0, 5'd0, 32'h0); drive_issue(1'b1, 5'd9);
    step(); drive_issue(1'b0, 5'd0);
    sample(); check_bit("r032_set_wins", bus.RS1_BUSY, 1'b1);
    step(); drive_mdu(1'b1, 5'd9, 32'h9B); expect_write(5'd9, 32'h9B);
    step(); drive_mdu(1'b0, 5'd0, 32'h0);
    step();
    sample(); check_bit("r032_cleanup", bus.RS1_BUSY, 1'b0);
    step(); drive_issue(1'b1, 5'd0); bus.RS1 = 5'd0;
    step(); drive_issue(1'b0, 5'd0);
    sample(); check_bit("r032_x0_never_busy", bus.RS1_BUSY, 1'b0);
    step();

    // address-0 requests are ignored
    drive_mdu(1'b1, 5'd8, 32'h33); expect_write(5'd8, 32'h33);
    step(); drive_mdu(1'b0, 5'd0, 32'h0); drive_wb(1'b1, 5'd0, 32'hDEAD);
    step(); drive_mdu(1'b1, 5'd0, 32'hBAD);
    sample(); check_bit("r033_ready_x0", bus.MDU_READY, 1'b1);
    check_addr("r033_head_granted", bus.WRITEADDRESS, 5'd8);
    step(); idle_inputs();
    repeat (3) step();

    // starvation: fairness forces the MDU in, otherwise WB keeps the port
    k = 0;
    for (int c = 0; c < 10; c++) begin
      drive_wb(1'b1, 5'(1 + k), 32'h1000 + 32'(k));
      if (c == 0) drive_mdu(1'b1, 5'd25, 32'h55);
      else        drive_mdu(1'b0, 5'd0, 32'h0);
      sample();
`ifdef RFWB_FAIRNESS_EN
      check_bit($sformatf("r034_stall_c%0d", c), bus.STALL, c == 5);
      check_bit($sformatf("r034_force_c%0d", c), dbg_state == FORCE, c == 5);
      if (c == 5) expect_write(5'd25, 32'h55);
      else begin
        expect_write(5'(1 + k), 32'h1000 + 32'(k));
        k++;
      end
`else
      check_bit($sformatf("r027_stall_c%0d", c), bus.STALL, 1'b0);
      expect_write(5'(1 + k), 32'h1000 + 32'(k));
      k++;
`endif
      step();
    end
`ifndef RFWB_FAIRNESS_EN
    expect_write(5'd25, 32'h55);
`endif
    idle_inputs();
    repeat (4) step();

    // reset with two queued results and x3 busy
    drive_issue(1'b1, 5'd3); drive_wb(1'b1, 5'd15, 32'h15); drive_mdu(1'b1, 5'd3, 32'h333);
    expect_write(5'd15, 32'h15);
    step(); drive_issue(1'b0, 5'd0); drive_wb(1'b1, 5'd16, 32'h16); drive_mdu(1'b1, 5'd4, 32'h444);
    expect_write(5'd16, 32'h16); bus.RS1 = 5'd3;
    sample(); check_bit("r035_busy_before", bus.RS1_BUSY, 1'b1);
    step(); drive_wb(1'b1, 5'd17, 32'h17); drive_mdu(1'b0, 5'd0, 32'h0);
    sample(); check_bit("r035_full", bus.MDU_READY, 1'b0);
    step(); drive_wb(1'b0, 5'd0, 32'h0); RESET = 1'b0;
    sample();
    check_bit ("r035_we",    bus.WRITEENABLE, 1'b0);
    check_addr("r035_addr",  bus.WRITEADDRESS, 5'd0);
    check_word("r035_data",  bus.WRITEDATA, 32'h0);
    check_bit ("r035_stall", bus.STALL, 1'b0);
    check_bit ("r035_ready", bus.MDU_READY, 1'b1);
    check_bit ("r035_rs1",   bus.RS1_BUSY, 1'b0);
    step(); step(); RESET = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      check_bit($sformatf("r035_no_write_c%0d", c), bus.WRITEENABLE, 1'b0);
      step();
    end

    repeat (3) step();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_writes: got %0d outstanding, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: number of buffered MDU results (power of two, at least 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: number of waiting cycles before the MDU is forced onto the write port.
REQ-003 CLK  in  1  single clock; all state changes on the posedge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 WB_VALID / WB_ADDR / WB_DATA  in  1/5/32  pipeline writeback request.
REQ-006 MDU_VALID / MDU_ADDR / MDU_DATA  in  1/5/32  multi-cycle mul/div result.
REQ-007 MDU_READY  out  1  the MDU result is accepted when MDU_VALID and MDU_READY are both high.
REQ-008 MDU_ISSUE / MDU_ISSUE_ADDR  in  1/5  mul/div op dispatched; marks its destination register busy.
REQ-009 RS1 / RS2  in  5/5  decode-stage source registers.
REQ-010 RS1_BUSY / RS2_BUSY  out  1/1  the source register has an outstanding MDU write.
REQ-011 STALL  out  1  freeze-pipeline request.
REQ-012 WRITEENABLE / WRITEADDRESS / WRITEDATA  out  1/5/32  register-file write port.

Function
REQ-013 The write port SHALL be registered: a granted request appears on WRITEENABLE/ADDR/DATA the next cycle, for exactly one cycle.
REQ-014 A request with address 0 (WB or MDU) SHALL count as no request: it is never queued, never granted, and never asserts WRITEENABLE.
REQ-015 Priority: WB_VALID SHALL win. The FIFO head SHALL be granted only in cycles with no valid WB request, or when in the FORCE state.
REQ-016 MDU results SHALL always enqueue first; there is no FIFO bypass. Handshake-to-WRITEENABLE latency is at least 2 cycles.
REQ-017 MDU_READY SHALL equal (registered count < FIFO_DEPTH). With a full FIFO it is low even if a dequeue happens in the same cycle.
REQ-018 Enqueue and dequeue in the same cycle SHALL both take effect; the count is unchanged.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Entries SHALL drain strictly in arrival order.
REQ-020 The scoreboard SHALL be a 32-bit busy vector: MDU_ISSUE with a nonzero address sets bit[MDU_ISSUE_ADDR]; a granted MDU write to address r clears bit[r].
REQ-021 If a set and a clear of the same bit occur in the same cycle, the set SHALL win.
REQ-022 RSn_BUSY SHALL be combinational: busy[RSn]. Bit 0 SHALL always read 0.
REQ-023 The block SHALL NOT reorder WAW writes; the issue logic stalls on busy destinations.

Reset
REQ-024 Asserting RESET (low) SHALL immediately clear all of: FIFO (count 0), scoreboard, state (IDLE), starvation counter, WRITEENABLE, WRITEADDRESS, WRITEDATA and STALL. MDU_READY SHALL be 1.
REQ-025 Reset in mid-operation SHALL discard all queued results with no write issued. Normal operation SHALL resume on the first posedge after deassertion.

Configuration
REQ-026 With RFWB_FAIRNESS_EN defined, a state machine SHALL run as follows:
- IDLE -> WAIT when the FIFO is non-empty and the head is not granted.
- In WAIT the counter increments each cycle the head is not granted, and the state returns to IDLE with the counter reset on a grant.
- WAIT -> FORCE when the counter reaches STARVE_LIMIT.
- In FORCE, STALL is high (registered), WB_VALID is ignored and the head is granted.
- FORCE -> IDLE (STALL low, counter 0) the following cycle.
REQ-027 Without RFWB_FAIRNESS_EN, STALL SHALL be tied to 0, the counter and state machine SHALL be absent, and the MDU may starve indefinitely.

Structure
REQ-028 Package rf_arb_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the arbiter state enum (IDLE, WAIT, FORCE).
REQ-029 The FIFO SHALL be the sub-module rf_arb_fifo (parameterised depth/width, push/pop/full/empty/count). Arbitration, scoreboard and output registers SHALL stay in the top.

Verification
REQ-030 Both WB(x5=0x11) and FIFO head(x7=0x22) present in cycle N -> cycle N+1 writes x5=0x11, cycle N+2 writes x7=0x22.
REQ-031 Three MDU results pushed back-to-back with WB continuously valid -> MDU_READY goes low after 2 accepts. The third result is held and accepted once the FIFO drains. Drain order is preserved.
REQ-032 MDU_ISSUE x9, then RS1=9 -> RS1_BUSY=1 until the cycle x9 is written. MDU_ISSUE x9 in the same cycle as the grant clearing x9 -> busy remains 1.
REQ-033 WB_ADDR=0 valid, MDU head pending -> head granted, WRITEENABLE never high for address 0.
REQ-034 FAIRNESS_EN, WB always valid, one MDU result queued -> STALL high for one cycle after 4 waiting cycles. The MDU write is issued and the held WB write follows.
REQ-035 RESET low with 2 entries queued and x3 busy -> all outputs 0, MDU_READY=1, RS_BUSY=0, and no write of the discarded data after release.
